// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b using a single full-adder cell, LSB first, computed as a + ~b + 1.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;
    logic [1:0]       fa_s;
    logic             last_s;
    logic             accept_s;

    // Returns {carry_out, sum} of a 1-bit full adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    assign fa_s     = full_add(a_r[cnt_r], ~b_r[cnt_r], carry_r);
    assign last_s   = (cnt_r == CW'(WIDTH - 1));
    assign accept_s = bus.start && (state_r != RUN);

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_nx_s = RUN;
                else           state_nx_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = RUN;
            end
            DONE: begin
                if (bus.start) state_nx_s = RUN;
                else           state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Controller, operand capture, serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            carry_r    <= 1'b0;
            cnt_r      <= '0;
            sr_r       <= '0;
            diff_r     <= '0;
            borrow_r   <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == RUN);
            done_r  <= (state_nx_s == DONE);
            if (accept_s) begin
                a_r     <= bus.a;
                b_r     <= bus.b;
                carry_r <= 1'b1;
                cnt_r   <= '0;
                sr_r    <= '0;
            end else if (state_r == RUN) begin
                sr_r    <= {fa_s[0], sr_r[WIDTH-1:1]};
                carry_r <= fa_s[1];
                cnt_r   <= cnt_r + CW'(1);
                // The final sum bit is the result MSB, so results publish on this same edge.
                if (last_s) begin
                    diff_r     <= {fa_s[0], sr_r[WIDTH-1:1]};
                    borrow_r   <= ~fa_s[1];
                    overflow_r <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (fa_s[0] ^ a_r[WIDTH-1]);
                end
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.diff     = diff_r;
    assign bus.borrow   = borrow_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues expected results, a monitor checks each done pulse.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t dummy;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_latency", cyc, e.due);
                    check("diff", {24'd0, bus.diff}, {24'd0, e.d});
                    check("borrow", {31'd0, bus.borrow}, {31'd0, e.bo});
                    check("overflow", {31'd0, bus.overflow}, {31'd0, e.ov});
                end
            end
        end
    endtask

    // Accept an operation at the next edge, then scramble the inputs.
    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic bo, input logic ov);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        q.push_back('{cyc + W, d, bo, ov});
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = 8'h5A;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic bo, input logic ov);
        launch(a, b, d, bo, ov);
        repeat (W - 1) tick();
        check("busy_last_run", {31'd0, bus.busy}, 32'd1);
        tick();
        check("busy_in_done", {31'd0, bus.busy}, 32'd0);
        tick();
        check("done_low_idle", {31'd0, bus.done}, 32'd0);
        check("diff_hold_idle", {24'd0, bus.diff}, {24'd0, d});
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (2) tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_diff", {24'd0, bus.diff}, 32'd0);
        check("rst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        rst_n = 1'b1;
        fork
            monitor();
        join_none
        tick();

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start during RUN is ignored
        launch(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
        repeat (2) tick();
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        tick();
        bus.start = 1'b0;
        repeat (W - 3) tick();
        check("busy_in_done_ign", {31'd0, bus.busy}, 32'd0);
        tick();

        // start held high across DONE: back-to-back accept
        bus.a     = 8'h20;
        bus.b     = 8'h30;
        bus.start = 1'b1;
        tick();
        q.push_back('{cyc + W, 8'hF0, 1'b1, 1'b0});
        bus.a = 8'hC8;
        bus.b = 8'h9C;
        repeat (W) tick();
        check("b2b_busy_in_done", {31'd0, bus.busy}, 32'd0);
        tick();
        q.push_back('{cyc + W, 8'h2C, 1'b0, 1'b0});
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        check("b2b_busy_rerise", {31'd0, bus.busy}, 32'd1);
        check("b2b_diff_hold_run", {24'd0, bus.diff}, 32'hF0);
        repeat (W) tick();
        check("b2b_busy_end", {31'd0, bus.busy}, 32'd0);
        tick();

        // reset in the middle of RUN abandons the operation
        launch(8'h44, 8'h11, 8'h33, 1'b0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dummy = q.pop_back();
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_diff", {24'd0, bus.diff}, 32'd0);
        check("midrst_borrow", {31'd0, bus.borrow}, 32'd0);
        check("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
        repeat (W) tick();
        run_op(8'h55, 8'h0A, 8'h4B, 1'b0, 1'b0);

        repeat (2) tick();
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request a new subtraction; sampled only when not busy.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  single-cycle pulse; result outputs are valid.
REQ-009 Port: diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  unsigned borrow out; high when a < b unsigned.
REQ-011 Port: overflow  output  1  signed two's-complement overflow of a minus b.

Function
REQ-012 The datapath SHALL be one 1-bit full-adder cell reused serially, LSB first, computing a[i] + ~b[i] + c; carry c starts at 1.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL latch a and b, set carry to 1, clear the bit counter and enter RUN.
REQ-015 In RUN, each edge SHALL process one bit: sum into the shift register, carry updated to majority(a[i], ~b[i], c), counter incremented.
REQ-016 After the edge processing bit WIDTH-1, the FSM SHALL enter DONE and update diff, borrow and overflow on that same edge.
REQ-017 Latency: start accepted at edge k gives done=1 for exactly the cycle after edge k+WIDTH (WIDTH+1 edges from start to done).
REQ-018 busy SHALL be high from edge k until edge k+WIDTH, and low in IDLE and DONE.
REQ-019 DONE without start SHALL return to IDLE on the next edge; done SHALL be high only in DONE.
REQ-020 start during RUN SHALL be ignored; a, b and the in-flight operation SHALL be unaffected.
REQ-021 start in DONE SHALL be accepted (back-to-back): done still pulses that cycle, then busy rises.
REQ-022 borrow SHALL equal the inverse of the final carry.
REQ-023 overflow SHALL be (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]), using the latched operands.
REQ-024 diff, borrow and overflow SHALL hold the last completed result until the next completion, including through IDLE and RUN.
REQ-025 Input changes on a and b after the accepting edge SHALL NOT affect the result.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, and clear carry, counter and operand registers.
REQ-027 Reset mid-RUN SHALL abandon the operation with no done pulse, and the outputs SHALL read 0.
REQ-028 rst_n has priority over start at the same edge.

Verification
REQ-029 WIDTH=8, a=0x05, b=0x03, start pulse -> after 9 edges done=1, diff=0x02, borrow=0, overflow=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0; a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1.
REQ-031 a=0x00, b=0x00 -> diff=0x00, borrow=0, overflow=0; a=0x00, b=0xFF -> diff=0x01, borrow=1, overflow=0.
REQ-032 Start 0x10-0x01, re-assert start with a=0xFF, b=0xFF at RUN cycle 3 -> ignored; result is diff=0x0F, borrow=0.
REQ-033 start held high across DONE -> done pulses once, busy re-rises next cycle, second result correct after 8 more edges.
REQ-034 rst_n=0 at RUN cycle 4 -> no done pulse, busy=0, diff=0x00 on the next cycle; a subsequent start completes normally.
